// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        if_valid,
    output logic        id_flush
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_drop;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_if_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;

    state_t      w_next_state;
    logic        w_pc_adv;
    logic        w_deliver;
    logic [31:0] w_del_instr;
    logic [31:0] w_del_pc;
    logic        w_buf_load;
    logic        w_drop_next;
    logic [31:0] w_redirect_pc;

    // Low two bits of the redirect target are discarded to keep fetches word aligned.
    assign w_redirect_pc   = redirect_pc & ~32'd3;

    assign imem_req        = (r_state == S_REQ) && !redirect_valid;
    assign imem_addr       = r_pc;
    assign instruction_out = r_instr;
    assign pc_out          = r_pc_out;
    assign if_valid        = r_if_valid;
    assign id_flush        = ~r_if_valid;

    // Next-state and datapath control: redirect wins over every other event.
    always_comb begin
        w_next_state = r_state;
        w_pc_adv     = 1'b0;
        w_deliver    = 1'b0;
        w_del_instr  = r_buf_instr;
        w_del_pc     = r_buf_pc;
        w_buf_load   = 1'b0;
        w_drop_next  = r_drop;
        case (r_state)
            S_REQ: begin
                if (!redirect_valid && imem_gnt) begin
                    w_pc_adv     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    if (imem_rvalid) begin
                        w_drop_next  = 1'b0;
                        w_next_state = S_REQ;
                    end else begin
                        w_drop_next  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    w_next_state = S_REQ;
                    if (r_drop) begin
                        w_drop_next = 1'b0;
                    end else if (!stall) begin
                        w_deliver   = 1'b1;
                        w_del_instr = imem_rdata;
                        w_del_pc    = r_req_pc;
                    end else begin
                        w_buf_load   = 1'b1;
                        w_next_state = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    w_next_state = S_REQ;
                end else if (!stall) begin
                    w_deliver    = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_REQ;
            end
        endcase
    end

    // State register, PC, skid buffer and drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_req_pc    <= 32'd0;
            r_drop      <= 1'b0;
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_drop  <= w_drop_next;
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_pc_adv) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            if (w_buf_load) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc    <= r_req_pc;
            end
        end
    end

    // IF/ID register: redirect squashes, stall holds, otherwise load or bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_out   <= 32'd0;
        end else if (redirect_valid) begin
            r_if_valid <= 1'b0;
            r_instr    <= NOP_INSTR;
        end else if (w_deliver) begin
            r_if_valid <= 1'b1;
            r_instr    <= w_del_instr;
            r_pc_out   <= w_del_pc;
        end else if (!stall) begin
            r_if_valid <= 1'b0;
            r_instr    <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        if_valid;
    logic        id_flush;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .if_valid        (if_valid),
        .id_flush        (id_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    task automatic set_in(input logic st, input logic rd, input logic [31:0] rdp,
                          input logic gn, input logic rv, input logic [31:0] rdt);
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rdp;
        imem_gnt       = gn;
        imem_rvalid    = rv;
        imem_rdata     = rdt;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({imem_req, imem_addr, if_valid, id_flush, instruction_out, pc_out} !==
            {1'b1, 32'h0, 1'b0, 1'b1, NOP, 32'h0}) begin
            failures++;
            $display("FAIL reset got=%h exp=%h",
                     {imem_req, imem_addr, if_valid, id_flush, instruction_out, pc_out},
                     {1'b1, 32'h0, 1'b0, 1'b1, NOP, 32'h0});
        end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        logic [31:0] epc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a   = 32'(i * 4);
            epc = (i > 0) ? 32'((i - 1) * 4) : 32'h0;
            set_in(0, 0, 0, 1, 0, 0);
            checks++;
            if ({imem_req, imem_addr, if_valid, id_flush, pc_out} !==
                {1'b1, a, (i > 0), !(i > 0), epc}) begin
                failures++;
                $display("FAIL stream_req%0d got=%h exp=%h", i,
                         {imem_req, imem_addr, if_valid, id_flush, pc_out},
                         {1'b1, a, (i > 0), !(i > 0), epc});
            end
            step();
            set_in(0, 0, 0, 0, 1, a);
            checks++;
            if ({imem_req, if_valid, id_flush} !== 3'b001) begin
                failures++;
                $display("FAIL stream_wait%0d got=%b exp=001", i, {imem_req, if_valid, id_flush});
            end
            step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({if_valid, id_flush, pc_out, instruction_out} !== {1'b1, 1'b0, 32'h8, 32'h8}) begin
            failures++;
            $display("FAIL stream_last got=%h exp=%h", {if_valid, id_flush, pc_out, instruction_out},
                     {1'b1, 1'b0, 32'h8, 32'h8});
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 1, 0, 0);
            step();
            set_in(0, 0, 0, 0, 1, 32'(i * 4));
            step();
        end
        set_in(1, 0, 0, 1, 0, 0);
        checks++;
        if ({imem_req, imem_addr, if_valid, pc_out} !== {1'b1, 32'h8, 1'b1, 32'h4}) begin
            failures++;
            $display("FAIL stall_req got=%h exp=%h", {imem_req, imem_addr, if_valid, pc_out},
                     {1'b1, 32'h8, 1'b1, 32'h4});
        end
        step();
        set_in(1, 0, 0, 0, 1, 32'h8);
        step();
        for (int i = 0; i < 2; i++) begin
            set_in(i == 1 ? 1'b0 : 1'b1, 0, 0, 1, 0, 0);
            checks++;
            if ({imem_req, if_valid, pc_out, instruction_out} !== {1'b0, 1'b1, 32'h4, 32'h4}) begin
                failures++;
                $display("FAIL stall_full%0d got=%h exp=%h", i, {imem_req, if_valid, pc_out, instruction_out},
                         {1'b0, 1'b1, 32'h4, 32'h4});
            end
            step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({imem_req, imem_addr, if_valid, pc_out, instruction_out} !==
            {1'b1, 32'hC, 1'b1, 32'h8, 32'h8}) begin
            failures++;
            $display("FAIL stall_release got=%h exp=%h", {imem_req, imem_addr, if_valid, pc_out, instruction_out},
                     {1'b1, 32'hC, 1'b1, 32'h8, 32'h8});
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        set_in(0, 0, 0, 1, 0, 0);
        step();
        set_in(0, 1, 32'h100, 0, 0, 0);
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL drop_redir_req got=%b exp=0", imem_req);
        end
        step();
        set_in(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        checks++;
        if ({imem_req, if_valid} !== 2'b00) begin
            failures++;
            $display("FAIL drop_wait got=%b exp=00", {imem_req, if_valid});
        end
        step();
        set_in(0, 0, 0, 1, 0, 0);
        checks++;
        if ({imem_req, imem_addr, if_valid, instruction_out} !== {1'b1, 32'h100, 1'b0, NOP}) begin
            failures++;
            $display("FAIL drop_stale got=%h exp=%h", {imem_req, imem_addr, if_valid, instruction_out},
                     {1'b1, 32'h100, 1'b0, NOP});
        end
        step();
        set_in(0, 0, 0, 0, 1, 32'h100);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({if_valid, pc_out, instruction_out} !== {1'b1, 32'h100, 32'h100}) begin
            failures++;
            $display("FAIL drop_next got=%h exp=%h", {if_valid, pc_out, instruction_out},
                     {1'b1, 32'h100, 32'h100});
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        set_in(0, 0, 0, 1, 0, 0);
        step();
        set_in(0, 1, 32'h203, 0, 1, 32'h55);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({imem_req, imem_addr, if_valid, id_flush, instruction_out, pc_out} !==
            {1'b1, 32'h200, 1'b0, 1'b1, NOP, 32'h0}) begin
            failures++;
            $display("FAIL redir_rvalid got=%h exp=%h",
                     {imem_req, imem_addr, if_valid, id_flush, instruction_out, pc_out},
                     {1'b1, 32'h200, 1'b0, 1'b1, NOP, 32'h0});
        end
    endtask

    task automatic test_gnt_hold();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
                failures++;
                $display("FAIL hold%0d got=%h exp=%h", i, {imem_req, imem_addr}, {1'b1, 32'h0});
            end
            step();
        end
        set_in(0, 1, 32'h40, 1, 0, 0);
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL hold_redir_req got=%b exp=0", imem_req);
        end
        step();
        set_in(0, 0, 0, 1, 0, 0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
            failures++;
            $display("FAIL hold_retarget got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h40});
        end
        step();
        set_in(0, 0, 0, 0, 1, 32'h40);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({if_valid, pc_out, imem_addr} !== {1'b1, 32'h40, 32'h44}) begin
            failures++;
            $display("FAIL hold_deliver got=%h exp=%h", {if_valid, pc_out, imem_addr}, {1'b1, 32'h40, 32'h44});
        end
    endtask

    task automatic test_reset_wait_and_wrap();
        do_reset();
        set_in(0, 0, 0, 1, 0, 0);
        step();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 1, 32'hBAD);
        checks++;
        if ({imem_req, imem_addr, if_valid, instruction_out, pc_out} !== {1'b1, 32'h0, 1'b0, NOP, 32'h0}) begin
            failures++;
            $display("FAIL rstwait_vals got=%h exp=%h", {imem_req, imem_addr, if_valid, instruction_out, pc_out},
                     {1'b1, 32'h0, 1'b0, NOP, 32'h0});
        end
        step();
        set_in(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        checks++;
        if ({if_valid, instruction_out, imem_addr} !== {1'b0, NOP, 32'h0}) begin
            failures++;
            $display("FAIL rstwait_late got=%h exp=%h", {if_valid, instruction_out, imem_addr}, {1'b0, NOP, 32'h0});
        end
        step();
        set_in(0, 0, 0, 1, 0, 0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL wrap_addr got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
        end
        step();
        set_in(0, 0, 0, 0, 1, 32'h11);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if ({imem_req, imem_addr, if_valid, pc_out, instruction_out} !==
            {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h11}) begin
            failures++;
            $display("FAIL wrap_next got=%h exp=%h", {imem_req, imem_addr, if_valid, pc_out, instruction_out},
                     {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h11});
        end
    endtask

    // Reference model: a PC, at most one fetch in flight (optionally doomed),
    // and a queue of fetched words waiting for decode to accept them.
    task automatic test_random();
        logic [31:0] m_pc;
        logic        m_busy;
        logic [31:0] m_req_pc;
        logic        m_drop;
        ent_t        m_held[$];
        ent_t        e;
        logic        m_valid;
        logic [31:0] m_instr;
        logic [31:0] m_pcout;
        logic        mem_pending;
        logic        e_req;
        logic        st, rd, gn, rv;
        logic [31:0] rdp, rdt;
        do_reset();
        m_pc = 32'h0; m_busy = 1'b0; m_req_pc = 32'h0; m_drop = 1'b0;
        m_valid = 1'b0; m_instr = NOP; m_pcout = 32'h0; mem_pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 8);
            rdp = $urandom;
            gn  = ($urandom_range(0, 99) < 60);
            rv  = mem_pending ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
            rdt = $urandom;
            set_in(st, rd, rdp, gn, rv, rdt);
            e_req = !m_busy && (m_held.size() == 0) && !rd;
            checks++;
            if ({imem_req, imem_addr, if_valid, id_flush, instruction_out, pc_out} !==
                {e_req, m_pc, m_valid, !m_valid, m_instr, m_pcout}) begin
                failures++;
                $display("FAIL random_c%0d got=%h exp=%h", c,
                         {imem_req, imem_addr, if_valid, id_flush, instruction_out, pc_out},
                         {e_req, m_pc, m_valid, !m_valid, m_instr, m_pcout});
            end
            if (rv && mem_pending) mem_pending = 1'b0;
            if (imem_req && gn) mem_pending = 1'b1;
            if (rd) begin
                m_pc = {rdp[31:2], 2'b00};
                m_held.delete();
                if (m_busy) begin
                    if (rv) begin
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
                m_valid = 1'b0;
                m_instr = NOP;
            end else begin
                if (e_req && gn) begin
                    m_busy   = 1'b1;
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end else if (m_busy && rv) begin
                    m_busy = 1'b0;
                    if (m_drop) m_drop = 1'b0;
                    else m_held.push_back('{instr: rdt, pc: m_req_pc});
                end
                if (!st && m_held.size() != 0) begin
                    e = m_held.pop_front();
                    m_valid = 1'b1;
                    m_instr = e.instr;
                    m_pcout = e.pc;
                end else if (!st) begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_gnt_hold();
        test_reset_wait_and_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
